// File: rtl/lcd_frame_reader.sv
// Streams RGB565 pixels from frame-memory port 2 onto an 8080-style LCD write bus.
// Each 32-bit word yields two pixels (low halfword first) with paced lcd_wr_n strobes.
module lcd_frame_reader #(
    parameter int ADDR_W         = 10,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    input  logic [31:0]       mem_readdata,
    output logic              lcd_cs_n,
    output logic              lcd_dc,
    output logic              lcd_wr_n,
    output logic [15:0]       lcd_data
);

    localparam int MAX_PHASE = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

    localparam logic [CNT_W-1:0]  LO_LAST   = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HI_LAST   = CNT_W'(WR_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_WR_LO,
        ST_WR_HI
    } state_t;

    state_t            state;
    logic              half;
    logic [CNT_W-1:0]  phase_cnt;
    logic [ADDR_W:0]   words_left;
    logic [15:0]       word_hi;

    // Only the high halfword needs keeping: the low one goes straight onto lcd_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            half           <= 1'b0;
            phase_cnt      <= '0;
            words_left     <= '0;
            word_hi        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            lcd_cs_n       <= 1'b1;
            lcd_dc         <= 1'b1;
            lcd_wr_n       <= 1'b1;
            lcd_data       <= '0;
        end else begin
            done   <= 1'b0;
            lcd_dc <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            state          <= ST_FETCH;
                            mem_address    <= base_addr;
                            mem_chipselect <= 1'b1;
                            words_left     <= word_count;
                            busy           <= 1'b1;
                            lcd_cs_n       <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    mem_chipselect <= 1'b0;
                    state          <= ST_WAIT;
                end
                ST_WAIT: begin
                    word_hi   <= mem_readdata[31:16];
                    lcd_data  <= mem_readdata[15:0];
                    lcd_wr_n  <= 1'b0;
                    half      <= 1'b0;
                    phase_cnt <= '0;
                    state     <= ST_WR_LO;
                end
                ST_WR_LO: begin
                    if (phase_cnt == LO_LAST) begin
                        phase_cnt <= '0;
                        lcd_wr_n  <= 1'b1;
                        state     <= ST_WR_HI;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                    end
                end
                ST_WR_HI: begin
                    if (phase_cnt != HI_LAST) begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                    end else begin
                        phase_cnt <= '0;
                        if (!half) begin
                            lcd_data <= word_hi;
                            lcd_wr_n <= 1'b0;
                            half     <= 1'b1;
                            state    <= ST_WR_LO;
                        end else if (words_left != LAST_WORD) begin
                            // Address wraps naturally at the top of the memory.
                            words_left     <= words_left - LAST_WORD;
                            mem_address    <= mem_address + ADDR_ONE;
                            mem_chipselect <= 1'b1;
                            state          <= ST_FETCH;
                        end else begin
                            words_left <= '0;
                            busy       <= 1'b0;
                            lcd_cs_n   <= 1'b1;
                            done       <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Directed bench for lcd_frame_reader: a default-timed instance and a 1/3-cycle strobe instance
// share a behavioural frame memory; expected pixels are queued at start and popped per wr_n rise.
module tb_lcd_frame_reader;

    logic        clk;
    logic        reset;
    logic        start          [2];
    logic [9:0]  base_addr      [2];
    logic [10:0] word_count     [2];
    logic        busy           [2];
    logic        done           [2];
    logic [9:0]  mem_address    [2];
    logic        mem_chipselect [2];
    logic [31:0] mem_readdata   [2];
    logic        lcd_cs_n       [2];
    logic        lcd_dc         [2];
    logic        lcd_wr_n       [2];
    logic [15:0] lcd_data       [2];

    logic [31:0] mem [1024];
    logic [9:0]  rd_addr [2];
    logic [15:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    lcd_frame_reader #(.ADDR_W(10), .WR_LOW_CYCLES(2), .WR_HIGH_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start[0]), .base_addr(base_addr[0]),
        .word_count(word_count[0]), .busy(busy[0]), .done(done[0]),
        .mem_address(mem_address[0]), .mem_chipselect(mem_chipselect[0]),
        .mem_readdata(mem_readdata[0]), .lcd_cs_n(lcd_cs_n[0]), .lcd_dc(lcd_dc[0]),
        .lcd_wr_n(lcd_wr_n[0]), .lcd_data(lcd_data[0])
    );

    lcd_frame_reader #(.ADDR_W(10), .WR_LOW_CYCLES(1), .WR_HIGH_CYCLES(3)) dut_sweep (
        .clk(clk), .reset(reset), .start(start[1]), .base_addr(base_addr[1]),
        .word_count(word_count[1]), .busy(busy[1]), .done(done[1]),
        .mem_address(mem_address[1]), .mem_chipselect(mem_chipselect[1]),
        .mem_readdata(mem_readdata[1]), .lcd_cs_n(lcd_cs_n[1]), .lcd_dc(lcd_dc[1]),
        .lcd_wr_n(lcd_wr_n[1]), .lcd_data(lcd_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-address, asynchronous-output RAM: data follows the registered address.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (mem_chipselect[i]) rd_addr[i] <= mem_address[i];
    end
    assign mem_readdata[0] = mem[rd_addr[0]];
    assign mem_readdata[1] = mem[rd_addr[1]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int inst, input int base, input int count);
        @(negedge clk);
        start[inst]      = 1'b1;
        base_addr[inst]  = 10'(base);
        word_count[inst] = 11'(count);
        for (int w = 0; w < count; w++) begin
            logic [31:0] word;
            word = mem[(base + w) % 1024];
            exp_q.push_back(word[15:0]);
            exp_q.push_back(word[31:16]);
        end
        @(posedge clk);
        #1 start[inst] = 1'b0;
    endtask

    // Follows one burst from the cycle after the start edge; poke >= 0 fires a stray start there.
    task automatic checkOutput(input int inst, input int words, input int lo, input int hi,
                               input int poke);
        int  busy_cycles = 0, lo_cnt = 0, hi_cnt = 0, pix = 0, cs_bad = 0, done_early = 0;
        bit  prev_wr = 1'b1, saw_busy = 1'b0, fin = 1'b0;
        int  exp_cycles = words * (2 + 2 * (lo + hi));
        for (int c = 0; c < exp_cycles + 40 && !fin; c++) begin
            logic w;
            @(negedge clk);
            w = lcd_wr_n[inst];
            if (busy[inst]) begin
                saw_busy = 1'b1;
                busy_cycles++;
                if (lcd_cs_n[inst] !== 1'b0) cs_bad++;
                if (done[inst] !== 1'b0) done_early++;
            end else if (saw_busy) begin
                check("done_pulse", 32'(done[inst]), 32'd1);
                check("cs_n_after", 32'(lcd_cs_n[inst]), 32'd1);
                fin = 1'b1;
            end
            if (!prev_wr && w) begin
                check("pixel_data", 32'(lcd_data[inst]), (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);
                check("low_phase", 32'(lo_cnt), 32'(lo));
                pix++;
                hi_cnt = 0;
            end
            if (prev_wr && !w) begin
                if (pix % 2 == 1) check("high_phase", 32'(hi_cnt), 32'(hi));
                lo_cnt = 0;
            end
            if (!w) lo_cnt++;
            else hi_cnt++;
            prev_wr = w;
            if (c == poke) begin
                start[inst]      = 1'b1;
                base_addr[inst]  = 10'd300;
                word_count[inst] = 11'd5;
            end else if (c == poke + 1) begin
                start[inst] = 1'b0;
            end
        end
        check("burst_timeout", 32'(fin), 32'd1);
        check("busy_cycles", 32'(busy_cycles), 32'(exp_cycles));
        check("pixel_count", 32'(pix), 32'(2 * words));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("cs_n_low_in_burst", 32'(cs_bad), 32'd0);
        check("done_while_busy", 32'(done_early), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done[inst]), 32'd0);
    endtask

    initial begin
        int done_seen, busy_seen;
        for (int i = 0; i < 1024; i++)
            mem[i] = {16'(i * 7 + 16'h1111), 16'(i) ^ 16'hA5A5};
        mem[5] = 32'hF800_07E0;
        for (int i = 0; i < 2; i++) begin
            start[i]      = 1'b0;
            base_addr[i]  = '0;
            word_count[i] = '0;
        end
        reset = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_done", 32'(done[i]), 32'd0);
            check("rst_cs_n", 32'(lcd_cs_n[i]), 32'd1);
            check("rst_dc", 32'(lcd_dc[i]), 32'd1);
            check("rst_wr_n", 32'(lcd_wr_n[i]), 32'd1);
            check("rst_data", 32'(lcd_data[i]), 32'd0);
            check("rst_addr", 32'(mem_address[i]), 32'd0);
            check("rst_memcs", 32'(mem_chipselect[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] single word at address 5");
        applyStimulus(0, 5, 1);
        checkOutput(0, 1, 2, 2, -1);

        $display("[TB] three words wrapping 1022 -> 0");
        applyStimulus(0, 1022, 3);
        checkOutput(0, 3, 2, 2, -1);

        $display("[TB] zero word count");
        applyStimulus(0, 7, 0);
        @(negedge clk);
        check("zero_done", 32'(done[0]), 32'd1);
        check("zero_busy", 32'(busy[0]), 32'd0);
        check("zero_cs_n", 32'(lcd_cs_n[0]), 32'd1);
        check("zero_wr_n", 32'(lcd_wr_n[0]), 32'd1);
        check("zero_memcs", 32'(mem_chipselect[0]), 32'd0);
        @(negedge clk);
        check("zero_done_clear", 32'(done[0]), 32'd0);

        $display("[TB] stray start mid-burst");
        applyStimulus(0, 20, 2);
        checkOutput(0, 2, 2, 2, 7);

        $display("[TB] reset during low phase of word 2");
        applyStimulus(0, 10, 3);
        repeat (12) @(posedge clk);
        #1 check("pre_reset_wr_lo", 32'(lcd_wr_n[0]), 32'd0);
        #1 reset = 1'b1;
        #1;
        check("midrst_wr_n", 32'(lcd_wr_n[0]), 32'd1);
        check("midrst_cs_n", 32'(lcd_cs_n[0]), 32'd1);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_done", 32'(done[0]), 32'd0);
        check("midrst_addr", 32'(mem_address[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        done_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done[0] !== 1'b0) done_seen++;
            if (busy[0] !== 1'b0) busy_seen++;
        end
        check("no_done_after_reset", 32'(done_seen), 32'd0);
        check("idle_after_reset", 32'(busy_seen), 32'd0);

        $display("[TB] normal burst after reset");
        applyStimulus(0, 40, 2);
        checkOutput(0, 2, 2, 2, -1);

        $display("[TB] low=1 high=3 instance, four words");
        applyStimulus(1, 100, 4);
        checkOutput(1, 4, 1, 3, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
